mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 15 +
 rtl/rr_pick2.sv | 17 +
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the two-port memory arbiter: ownership FSM states and grant tag.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  typedef enum logic {
    GNT_P0 = 1'b0,
    GNT_P1 = 1'b1
  } gnt_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes opposite to the last grant.
module rr_pick2
  import mem_pkg::*;
(
  input  logic [1:0] valid_i,
  input  gnt_e       last_grant_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = valid_i;
    if (valid_i == 2'b11) begin
      gnt_o = (last_grant_i == GNT_P1) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter onto one single-cycle registered memory, with bounded bursts per owner
// and a one-cycle tagged read-return path.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int WIDTH     = 32,
  parameter int BURST_MAX = 4,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             aresetn_i,
  input  logic             p0_valid_i,
  output logic             p0_ready_o,
  input  logic             p0_we_i,
  input  logic [AW-1:0]    p0_addr_i,
  input  logic [WIDTH-1:0] p0_wdata_i,
  output logic             p0_rvalid_o,
  input  logic             p1_valid_i,
  output logic             p1_ready_o,
  input  logic             p1_we_i,
  input  logic [AW-1:0]    p1_addr_i,
  input  logic [WIDTH-1:0] p1_wdata_i,
  output logic             p1_rvalid_o,
  output logic [WIDTH-1:0] rdata_o,
  output logic             mem_rw_en_o,
  output logic [AW-1:0]    mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  input  logic [WIDTH-1:0] mem_rdata_i
);

  localparam int            CW      = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  gnt_e          last_q, last_d;
  logic [1:0]    rvalid_q, rvalid_d;

  logic [1:0] valid;
  logic [1:0] rr_gnt;
  logic [1:0] gnt;
  logic       own;
  logic       xfer;
  logic       sel;

  assign valid = {p1_valid_i, p0_valid_i};

  rr_pick2 u_rr_pick2 (
    .valid_i      (valid),
    .last_grant_i (last_q),
    .gnt_o        (rr_gnt)
  );

  // The owner keeps the bus until its burst is spent and the other side is waiting.
  always_comb begin
    gnt = 2'b00;
    own = 1'b0;
    case (state_q)
      ST_IDLE: gnt = rr_gnt;
      ST_OWN0, ST_OWN1: begin
        own = (state_q == ST_OWN1);
        if (valid[own] && ((cnt_q < CNT_MAX) || !valid[~own])) begin
          gnt[own] = 1'b1;
        end else if (valid[~own]) begin
          gnt[~own] = 1'b1;
        end
      end
      default: gnt = 2'b00;
    endcase
    gnt = gnt & {2{aresetn_i}};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    rvalid_d = {gnt[1] & ~p1_we_i, gnt[0] & ~p0_we_i};
    if (|gnt) begin
      state_d = gnt[1] ? ST_OWN1 : ST_OWN0;
      last_d  = gnt[1] ? GNT_P1 : GNT_P0;
      if (state_d == state_q) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      end else begin
        cnt_d = CW'(1);
      end
    end else if (state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      last_q   <= GNT_P1;
      rvalid_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign xfer        = |gnt;
  assign sel         = gnt[1];
  assign p0_ready_o  = gnt[0];
  assign p1_ready_o  = gnt[1];
  assign mem_rw_en_o = xfer & (sel ? p1_we_i : p0_we_i);
  assign mem_addr_o  = xfer ? (sel ? p1_addr_i : p0_addr_i) : '0;
  assign mem_wdata_o = xfer ? (sel ? p1_wdata_i : p0_wdata_i) : '0;

  // Memory data is shared; the registered tag says whose read it is.
  assign p0_rvalid_o = rvalid_q[0];
  assign p1_rvalid_o = rvalid_q[1];
  assign rdata_o     = mem_rdata_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a rule-level arbitration and memory model.
module tb_mem_arbiter;

  localparam int DEPTH     = 256;
  localparam int WIDTH     = 32;
  localparam int BURST_MAX = 4;
  localparam int AW        = 8;

  logic             clk = 1'b0;
  logic             rstn;
  logic             p0_valid, p0_ready, p0_we, p0_rvalid;
  logic [AW-1:0]    p0_addr;
  logic [WIDTH-1:0] p0_wdata;
  logic             p1_valid, p1_ready, p1_we, p1_rvalid;
  logic [AW-1:0]    p1_addr;
  logic [WIDTH-1:0] p1_wdata;
  logic [WIDTH-1:0] rdata, mem_wdata;
  logic [WIDTH-1:0] mem_rdata = '0;
  logic             mem_rw_en;
  logic [AW-1:0]    mem_addr;

  logic [WIDTH-1:0] mem_arr [DEPTH];
  logic [WIDTH-1:0] ref_mem [DEPTH];

  int errors = 0;
  int checks = 0;

  int          m_owner;
  int          m_streak;
  int          m_last;
  bit          m_rv0, m_rv1;
  logic [31:0] m_rdata;
  int          obs_gnt;

  int rr_seq [9]    = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
  int burst_seq [4] = '{1, 1, 1, 0};

  always #5 clk = ~clk;

  mem_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH), .BURST_MAX(BURST_MAX)) dut (
    .clk_i       (clk),
    .aresetn_i   (rstn),
    .p0_valid_i  (p0_valid),
    .p0_ready_o  (p0_ready),
    .p0_we_i     (p0_we),
    .p0_addr_i   (p0_addr),
    .p0_wdata_i  (p0_wdata),
    .p0_rvalid_o (p0_rvalid),
    .p1_valid_i  (p1_valid),
    .p1_ready_o  (p1_ready),
    .p1_we_i     (p1_we),
    .p1_addr_i   (p1_addr),
    .p1_wdata_i  (p1_wdata),
    .p1_rvalid_o (p1_rvalid),
    .rdata_o     (rdata),
    .mem_rw_en_o (mem_rw_en),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  // Registered-read memory sitting outside the arbiter.
  always @(posedge clk) begin
    if (mem_rw_en) mem_arr[mem_addr] <= mem_wdata;
    mem_rdata <= mem_arr[mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input bit v0, input bit v1);
    int o, x;
    bit vo, vx;
    if (m_owner < 0) begin
      if (v0 && v1) return 1 - m_last;
      if (v0) return 0;
      if (v1) return 1;
      return -1;
    end
    o  = m_owner;
    x  = 1 - o;
    vo = (o == 0) ? v0 : v1;
    vx = (x == 0) ? v0 : v1;
    if (vo && (m_streak < BURST_MAX || !vx)) return o;
    if (vx) return x;
    return -1;
  endfunction

  // Called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    int          win;
    bit          we;
    logic [7:0]  ad;
    logic [31:0] wd;
    #1;
    if (!rstn) begin
      chk("rst_ready0", 64'(p0_ready), 64'(0));
      chk("rst_ready1", 64'(p1_ready), 64'(0));
      chk("rst_rw_en", 64'(mem_rw_en), 64'(0));
      chk("rst_rvalid0", 64'(p0_rvalid), 64'(0));
      chk("rst_rvalid1", 64'(p1_rvalid), 64'(0));
      m_owner = -1; m_streak = 0; m_last = 1; m_rv0 = 0; m_rv1 = 0;
      obs_gnt = -1;
    end else begin
      win = pick(p0_valid, p1_valid);
      we  = (win == 0) ? p0_we : p1_we;
      ad  = (win == 0) ? p0_addr : p1_addr;
      wd  = (win == 0) ? p0_wdata : p1_wdata;
      chk("ready0", 64'(p0_ready), 64'(win == 0));
      chk("ready1", 64'(p1_ready), 64'(win == 1));
      chk("mem_rw_en", 64'(mem_rw_en), 64'(win >= 0 && we));
      chk("mem_addr", 64'(mem_addr), 64'((win >= 0) ? ad : 8'd0));
      chk("mem_wdata", 64'(mem_wdata), 64'((win >= 0) ? wd : 32'd0));
      chk("rvalid0", 64'(p0_rvalid), 64'(m_rv0));
      chk("rvalid1", 64'(p1_rvalid), 64'(m_rv1));
      if (m_rv0 || m_rv1) chk("rdata", 64'(rdata), 64'(m_rdata));
      obs_gnt = p0_ready ? 0 : (p1_ready ? 1 : -1);
      m_rv0 = 0; m_rv1 = 0;
      if (win >= 0) begin
        if (win == m_owner) m_streak = (m_streak < BURST_MAX) ? m_streak + 1 : BURST_MAX;
        else m_streak = 1;
        m_owner = win;
        m_last  = win;
        if (we) ref_mem[ad] = wd;
        else begin
          m_rdata = ref_mem[ad];
          if (win == 0) m_rv0 = 1; else m_rv1 = 1;
        end
      end else begin
        m_owner = -1; m_streak = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_ports();
    p0_valid = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_valid = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
  endtask

  task automatic apply_reset();
    idle_ports();
    rstn = 0;
    step();
    step();
    rstn = 1;
    step();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_arr[i] = '0;
      ref_mem[i] = '0;
    end
    rstn = 0;
    idle_ports();
    m_owner = -1; m_streak = 0; m_last = 1; m_rv0 = 0; m_rv1 = 0; m_rdata = '0; obs_gnt = -1;
    @(negedge clk);
    apply_reset();

    // Write then read back through port 0.
    p0_valid = 1; p0_we = 1; p0_addr = 8'd5; p0_wdata = 32'hDEADBEEF;
    step();
    chk("wr_gnt", 64'(obs_gnt), 64'(0));
    p0_we = 0; p0_wdata = '0;
    step();
    chk("rd_gnt", 64'(obs_gnt), 64'(0));
    p0_valid = 0;
    #1;
    chk("rd_rvalid", 64'(p0_rvalid), 64'(1));
    chk("rd_data", 64'(rdata), 64'(32'hDEADBEEF));
    step();
    step();

    // Round-robin bursts from a fresh tie.
    apply_reset();
    p0_valid = 1; p0_addr = 8'd1; p1_valid = 1; p1_addr = 8'd2;
    for (int i = 0; i < 9; i++) begin
      step();
      chk("rr_seq", 64'(obs_gnt), 64'(rr_seq[i]));
    end
    idle_ports();
    step();
    step();

    // Port 1 streams: first load distinct data, then read it back in order.
    for (int i = 0; i < 10; i++) begin
      p1_valid = 1; p1_we = 1; p1_addr = AW'(i); p1_wdata = 32'hA500_0000 + i;
      step();
      chk("p1_wr_stream", 64'(obs_gnt), 64'(1));
    end
    p1_we = 0; p1_wdata = '0;
    for (int i = 0; i < 10; i++) begin
      p1_addr = AW'(i);
      step();
      chk("p1_rd_stream", 64'(obs_gnt), 64'(1));
    end
    idle_ports();
    step();
    step();

    // Owner drops valid mid-burst while the other side waits.
    apply_reset();
    p0_valid = 1; p0_addr = 8'd7; p1_valid = 1; p1_addr = 8'd8;
    step();
    step();
    p0_valid = 0;
    step();
    chk("drop_switch", 64'(obs_gnt), 64'(1));
    p0_valid = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("burst_restart", 64'(obs_gnt), 64'(burst_seq[i]));
    end
    idle_ports();
    step();
    step();

    // Reset the cycle after a port 0 read; its response must vanish.
    p0_valid = 1; p0_addr = 8'd5;
    step();
    chk("pre_rst_gnt", 64'(obs_gnt), 64'(0));
    p0_valid = 0;
    rstn = 0;
    #1;
    chk("rst_drop_rv", 64'(p0_rvalid), 64'(0));
    step();
    rstn = 1;
    step();
    chk("post_rst_rv", 64'(p0_rvalid), 64'(0));
    p0_valid = 1; p1_valid = 1;
    step();
    chk("post_rst_tie", 64'(obs_gnt), 64'(0));
    idle_ports();
    step();

    // Random traffic with the occasional reset.
    for (int n = 0; n < 3000; n++) begin
      p0_valid = ($urandom_range(0, 3) != 0);
      p0_we    = $urandom_range(0, 1) == 1;
      p0_addr  = AW'($urandom_range(0, 15));
      p0_wdata = $urandom;
      p1_valid = ($urandom_range(0, 2) != 0);
      p1_we    = $urandom_range(0, 1) == 1;
      p1_addr  = AW'($urandom_range(0, 15));
      p1_wdata = $urandom;
      rstn     = ($urandom_range(0, 299) != 0);
      step();
      if (p0_rvalid && p1_rvalid) chk("rvalid_excl", 64'(1), 64'(0));
    end
    rstn = 1;
    idle_ports();
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
